// File: rtl/processorci_bus_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package processorci_bus_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_INSTR = 1'b0,
      REQ_DATA  = 1'b1
   } req_id_t;

   localparam int ARB_REQS = 2;

   // Width of the timeout counter; a disabled timeout (0) still keeps one bit.
   function automatic int tmo_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/processorci_bus_arbiter_if.sv
// Bundle of requester-side (instr/data) and memory-side Wishbone signals.
// Latency: none (wires only).
// Backpressure: carried by the ack signals; the slave modport is the arbiter's view.
interface processorci_bus_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   import processorci_bus_pkg::*;

   localparam int STRB_W = DATA_WIDTH / 8;

   logic                  instr_cyc_i,   data_cyc_i;
   logic                  instr_stb_i,   data_stb_i;
   logic                  instr_we_i,    data_we_i;
   logic [STRB_W-1:0]     instr_wstrb_i, data_wstrb_i;
   logic [ADDR_WIDTH-1:0] instr_addr_i,  data_addr_i;
   logic [DATA_WIDTH-1:0] instr_data_i,  data_data_i;
   logic [DATA_WIDTH-1:0] instr_data_o,  data_data_o;
   logic                  instr_ack_o,   data_ack_o;
   logic                  instr_err_o,   data_err_o;

   logic                  mem_cyc_o, mem_stb_o, mem_we_o;
   logic [STRB_W-1:0]     mem_wstrb_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_data_o;
   logic [DATA_WIDTH-1:0] mem_data_i;
   logic                  mem_ack_i;

   logic [ARB_REQS-1:0]   grant_o;

   modport slave (
      input  instr_cyc_i, instr_stb_i, instr_we_i, instr_wstrb_i, instr_addr_i, instr_data_i,
      input  data_cyc_i,  data_stb_i,  data_we_i,  data_wstrb_i,  data_addr_i,  data_data_i,
      output instr_data_o, instr_ack_o, instr_err_o,
      output data_data_o,  data_ack_o,  data_err_o,
      output mem_cyc_o, mem_stb_o, mem_we_o, mem_wstrb_o, mem_addr_o, mem_data_o,
      input  mem_data_i, mem_ack_i,
      output grant_o
   );

   modport master (
      output instr_cyc_i, instr_stb_i, instr_we_i, instr_wstrb_i, instr_addr_i, instr_data_i,
      output data_cyc_i,  data_stb_i,  data_we_i,  data_wstrb_i,  data_addr_i,  data_data_i,
      input  instr_data_o, instr_ack_o, instr_err_o,
      input  data_data_o,  data_ack_o,  data_err_o,
      input  mem_cyc_o, mem_stb_o, mem_we_o, mem_wstrb_o, mem_addr_o, mem_data_o,
      output mem_data_i, mem_ack_i,
      input  grant_o
   );

endinterface

// File: rtl/processorci_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone memory port between instr and data buses.
// Latency: 1 cycle request-to-grant, combinational ack/data return, 1 idle turnaround.
// Backpressure: requester waits for ack; a stalled memory is released after TIMEOUT_CYCLES.
module processorci_bus_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk_core,
   input  logic                     rst_core,
   processorci_bus_arbiter_if.slave bus
);
   import processorci_bus_pkg::*;

   localparam int                STRB_W   = DATA_WIDTH / 8;
   localparam int                TMO_W    = tmo_width(TIMEOUT_CYCLES);
   localparam bit                TMO_EN   = (TIMEOUT_CYCLES > 0);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   arb_state_t       state_q, state_d;
   req_id_t          last_q,  last_d;
   logic [TMO_W-1:0] tmo_q,   tmo_d;

   // Signals of whichever requester currently owns the port
   req_id_t               g_id;
   logic                  g_cyc, g_stb, g_we;
   logic [STRB_W-1:0]     g_wstrb;
   logic [ADDR_WIDTH-1:0] g_addr;
   logic [DATA_WIDTH-1:0] g_data;

   logic instr_req, data_req;
   assign instr_req = bus.instr_cyc_i & bus.instr_stb_i;
   assign data_req  = bus.data_cyc_i  & bus.data_stb_i;

   // Select the owning requester's bus; zero when nobody is granted
   always_comb begin
      g_id    = REQ_INSTR;
      g_cyc   = 1'b0;
      g_stb   = 1'b0;
      g_we    = 1'b0;
      g_wstrb = '0;
      g_addr  = '0;
      g_data  = '0;
      if (state_q == GNT_I) begin
         g_cyc   = bus.instr_cyc_i;
         g_stb   = bus.instr_stb_i;
         g_we    = bus.instr_we_i;
         g_wstrb = bus.instr_wstrb_i;
         g_addr  = bus.instr_addr_i;
         g_data  = bus.instr_data_i;
      end else if (state_q == GNT_D) begin
         g_id    = REQ_DATA;
         g_cyc   = bus.data_cyc_i;
         g_stb   = bus.data_stb_i;
         g_we    = bus.data_we_i;
         g_wstrb = bus.data_wstrb_i;
         g_addr  = bus.data_addr_i;
         g_data  = bus.data_data_i;
      end
   end

   // Arbitration, transaction exit conditions and response routing
   always_comb begin
      state_d          = state_q;
      last_d           = last_q;
      tmo_d            = '0;
      bus.mem_cyc_o    = 1'b0;
      bus.mem_stb_o    = 1'b0;
      bus.mem_we_o     = 1'b0;
      bus.mem_wstrb_o  = '0;
      bus.mem_addr_o   = '0;
      bus.mem_data_o   = '0;
      bus.instr_ack_o  = 1'b0;
      bus.instr_err_o  = 1'b0;
      bus.instr_data_o = '0;
      bus.data_ack_o   = 1'b0;
      bus.data_err_o   = 1'b0;
      bus.data_data_o  = '0;
      case (state_q)
         IDLE: begin
            // Ties go to whoever was not served last
            if (instr_req && data_req) begin
               state_d = (last_q == REQ_DATA) ? GNT_I : GNT_D;
            end else if (instr_req) begin
               state_d = GNT_I;
            end else if (data_req) begin
               state_d = GNT_D;
            end
         end
         GNT_I, GNT_D: begin
            tmo_d           = tmo_q + TMO_W'(1);
            bus.mem_cyc_o   = g_cyc;
            bus.mem_stb_o   = g_stb;
            bus.mem_we_o    = g_we;
            bus.mem_wstrb_o = g_wstrb;
            bus.mem_addr_o  = g_addr;
            bus.mem_data_o  = g_data;
            if (g_id == REQ_INSTR) begin
               bus.instr_ack_o  = bus.mem_ack_i;
               bus.instr_data_o = bus.mem_data_i;
            end else begin
               bus.data_ack_o  = bus.mem_ack_i;
               bus.data_data_o = bus.mem_data_i;
            end
            // Ack beats abort, abort beats timeout (a departed requester gets no error)
            if (bus.mem_ack_i) begin
               state_d = IDLE;
               last_d  = g_id;
               tmo_d   = '0;
            end else if (!g_cyc) begin
               state_d = IDLE;
               tmo_d   = '0;
            end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
               state_d       = IDLE;
               last_d        = g_id;
               tmo_d         = '0;
               bus.mem_cyc_o = 1'b0;
               bus.mem_stb_o = 1'b0;
               if (g_id == REQ_INSTR) begin
                  bus.instr_err_o = 1'b1;
               end else begin
                  bus.data_err_o = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, fairness pointer and timeout counter registers
   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         state_q <= IDLE;
         last_q  <= REQ_DATA;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus.grant_o = {state_q == GNT_D, state_q == GNT_I};

endmodule

// File: tb/tb_processorci_bus_arbiter.sv
// Self-checking bench for processorci_bus_arbiter: directed vector table,
// hand-written timeout/reset sequences, then random traffic against a model.
module tb_processorci_bus_arbiter;

   localparam int TMO = 8;

   logic clk;
   logic rst_core;

   processorci_bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   processorci_bus_arbiter #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_core(clk),
      .rst_core(rst_core),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  grant;
      logic        mcyc, mstb, mwe;
      logic [3:0]  mwstrb;
      logic [31:0] maddr, mwdat;
      logic        iack, dack, ierr, derr;
      logic [31:0] idat, ddat;
   } obs_t;

   typedef struct packed {
      logic       rst, icyc, dcyc, ack;
      logic [1:0] grant;
      logic       mcyc, iack, dack;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   logic        cyc_v[2], stb_v[2], we_v[2];
   logic [3:0]  wstrb_v[2];
   logic [31:0] addr_v[2], wdat_v[2];
   logic        mack;
   logic [31:0] mrdata;

   // Reference model: owner index (-1 = port free), granted-cycle count, last served
   int m_own, m_age, m_last;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive();
      bus.instr_cyc_i   = cyc_v[0];   bus.data_cyc_i   = cyc_v[1];
      bus.instr_stb_i   = stb_v[0];   bus.data_stb_i   = stb_v[1];
      bus.instr_we_i    = we_v[0];    bus.data_we_i    = we_v[1];
      bus.instr_wstrb_i = wstrb_v[0]; bus.data_wstrb_i = wstrb_v[1];
      bus.instr_addr_i  = addr_v[0];  bus.data_addr_i  = addr_v[1];
      bus.instr_data_i  = wdat_v[0];  bus.data_data_i  = wdat_v[1];
      bus.mem_ack_i     = mack;
      bus.mem_data_i    = mrdata;
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.grant  = bus.grant_o;
      o.mcyc   = bus.mem_cyc_o;
      o.mstb   = bus.mem_stb_o;
      o.mwe    = bus.mem_we_o;
      o.mwstrb = bus.mem_wstrb_o;
      o.maddr  = bus.mem_addr_o;
      o.mwdat  = bus.mem_data_o;
      o.iack   = bus.instr_ack_o;
      o.dack   = bus.data_ack_o;
      o.ierr   = bus.instr_err_o;
      o.derr   = bus.data_err_o;
      o.idat   = bus.instr_data_o;
      o.ddat   = bus.data_data_o;
      return o;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs for this cycle, then advance the model by one cycle
   task automatic model_step(output obs_t e);
      int r;
      e = '0;
      if (m_own >= 0) begin
         r        = m_own;
         e.grant  = (r == 0) ? 2'b01 : 2'b10;
         e.mcyc   = cyc_v[r];
         e.mstb   = stb_v[r];
         e.mwe    = we_v[r];
         e.mwstrb = wstrb_v[r];
         e.maddr  = addr_v[r];
         e.mwdat  = wdat_v[r];
         if (r == 0) begin e.iack = mack; e.idat = mrdata; end
         else        begin e.dack = mack; e.ddat = mrdata; end
         m_age++;
         if (mack) begin
            m_last = r; m_own = -1;
         end else if (!cyc_v[r]) begin
            m_own = -1;
         end else if (TMO > 0 && m_age == TMO) begin
            if (r == 0) e.ierr = 1'b1; else e.derr = 1'b1;
            e.mcyc = 1'b0; e.mstb = 1'b0;
            m_last = r; m_own = -1;
         end
      end else begin
         if (cyc_v[0] && stb_v[0] && cyc_v[1] && stb_v[1]) m_own = 1 - m_last;
         else if (cyc_v[0] && stb_v[0])                    m_own = 0;
         else if (cyc_v[1] && stb_v[1])                    m_own = 1;
         m_age = 0;
      end
      if (rst_core) begin
         m_own = -1; m_last = 1; m_age = 0;
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic ic, input logic dc, input logic ak,
                               input logic [1:0] g, input logic mc, input logic ia, input logic da);
      vec_t v;
      v.rst = rst; v.icyc = ic; v.dcyc = dc; v.ack = ak;
      v.grant = g; v.mcyc = mc; v.iack = ia; v.dack = da;
      return v;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      vec_t vecs[16];
      obs_t e, o;
      int   gcnt, err_at;
      logic cyc_at_err;

      // Requester payloads for the directed part
      we_v[0] = 1'b0; wstrb_v[0] = 4'h3; addr_v[0] = 32'h100;  wdat_v[0] = 32'hCAFEF00D;
      we_v[1] = 1'b1; wstrb_v[1] = 4'hF; addr_v[1] = 32'h2000; wdat_v[1] = 32'h12345678;
      mrdata  = 32'hDEADBEEF;

      //                rst   icyc  dcyc  ack   grant  mcyc  iack  dack
      vecs[0]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); // in reset
      vecs[1]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      vecs[2]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); // released, still idle
      vecs[3]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0); // boot tie -> instr
      vecs[4]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
      vecs[5]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0); // ack 2 cycles after grant
      vecs[6]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0); // turnaround
      vecs[7]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1); // data write
      vecs[8]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      vecs[9]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0); // alternation
      vecs[10] = mk(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0); // idle ack ignored
      vecs[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
      vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1); // abort+ack -> ack
      vecs[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0); // abort, cyc falls
      vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0); // late ack ignored

      rst_core = 1'b1;
      cyc_v[0] = 1'b1; stb_v[0] = 1'b1; cyc_v[1] = 1'b1; stb_v[1] = 1'b1;
      mack = 1'b0;
      drive();
      tick();

      for (int i = 0; i < 16; i++) begin
         rst_core = vecs[i].rst;
         cyc_v[0] = vecs[i].icyc; stb_v[0] = vecs[i].icyc;
         cyc_v[1] = vecs[i].dcyc; stb_v[1] = vecs[i].dcyc;
         mack     = vecs[i].ack;
         drive();
         #3;
         e       = '0;
         e.grant = vecs[i].grant;
         e.mcyc  = vecs[i].mcyc;
         e.mstb  = vecs[i].mcyc;
         e.iack  = vecs[i].iack;
         e.dack  = vecs[i].dack;
         if (vecs[i].grant == 2'b01) begin
            e.maddr = 32'h100;  e.mwdat = 32'hCAFEF00D; e.mwstrb = 4'h3; e.idat = 32'hDEADBEEF;
         end else if (vecs[i].grant == 2'b10) begin
            e.maddr = 32'h2000; e.mwdat = 32'h12345678; e.mwstrb = 4'hF; e.mwe = 1'b1;
            e.ddat  = 32'hDEADBEEF;
         end
         check($sformatf("vec%0d", i), 256'(sample()), 256'(e));
         tick();
      end

      // Timeout: data request, memory never acks
      cyc_v[0] = 1'b0; stb_v[0] = 1'b0; cyc_v[1] = 1'b0; stb_v[1] = 1'b0; mack = 1'b0;
      drive(); tick(); tick();
      cyc_v[1] = 1'b1; stb_v[1] = 1'b1;
      drive();
      gcnt = 0; err_at = -1; cyc_at_err = 1'b1;
      for (int k = 0; k < 30 && err_at < 0; k++) begin
         #3;
         o = sample();
         if (o.grant == 2'b10) gcnt++;
         if (o.derr) begin
            err_at     = gcnt;
            cyc_at_err = o.mcyc;
         end else begin
            tick();
         end
      end
      check("tmo_err_cycle", 256'(err_at), 256'(8));
      check("tmo_mem_cyc_low", 256'(cyc_at_err), 256'(0));
      cyc_v[0] = 1'b1; stb_v[0] = 1'b1;
      drive(); tick(); #3;
      check("tmo_turnaround", 256'(bus.grant_o), 256'(2'b00));
      tick(); #3;
      check("tmo_next_grant", 256'(bus.grant_o), 256'(2'b01));

      // Complete the instr access so instr is last served, then reset during a data grant
      mack = 1'b1;
      drive(); tick();
      cyc_v[0] = 1'b0; stb_v[0] = 1'b0; mack = 1'b0;
      drive(); tick(); #3;
      check("rst_pre_grant", 256'({bus.grant_o, bus.mem_cyc_o}), 256'({2'b10, 1'b1}));
      rst_core = 1'b1;
      cyc_v[0] = 1'b1; stb_v[0] = 1'b1;
      drive(); tick(); #3;
      check("rst_mid_outputs", 256'(sample()), 256'(0));
      rst_core = 1'b0;
      drive(); tick(); #3;
      check("rst_first_grant", 256'(bus.grant_o), 256'(2'b01));

      // Random traffic against the model
      rst_core = 1'b1;
      drive(); tick();
      rst_core = 1'b0;
      m_own = -1; m_last = 1; m_age = 0;
      for (int c = 0; c < 3000; c++) begin
         bit stall_mode;
         stall_mode = ((c / 200) % 2) == 1;
         for (int r = 0; r < 2; r++) begin
            cyc_v[r]   = stall_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
            stb_v[r]   = ($urandom_range(0, 3) != 0);
            we_v[r]    = 1'($urandom_range(0, 1));
            wstrb_v[r] = 4'($urandom_range(0, 15));
            addr_v[r]  = $urandom;
            wdat_v[r]  = $urandom;
         end
         mack     = stall_mode ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
         mrdata   = $urandom;
         rst_core = ($urandom_range(0, 199) == 0);
         drive();
         #3;
         model_step(e);
         check($sformatf("rand%0d", c), 256'(sample()), 256'(e));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
